// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the MiniMIPS32 stall/flush controller:
// stall-vector encodings and the reset PC.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EXE  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

endpackage : pipe_stall_ctrl_pkg

// File: rtl/pipe_stall_ctrl_mem_wait_timer.sv
// Counts consecutive stalled MEM-wait cycles and forces a release
// once MEM_TIMEOUT of them have elapsed.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic clear,
  input  logic mem_req,
  input  logic mem_ack,
  output logic wait_stall,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] wcnt;
  logic             pending;

  // Requests seen during the flush cycle are ignored entirely.
  assign pending    = mem_req && !mem_ack && !flush;
  assign wait_stall = pending && (wcnt < LIMIT);
  assign timeout    = pending && (wcnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear || flush || !pending || timeout) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule : mem_wait_timer

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: prioritises MEM/EXE/ID stall requests,
// sequences the multi-cycle divider and registers the exception flush.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES  = 34,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               stallreq_id,
  input  logic               div_start,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               exc_valid,
  input  logic [31:0]        exc_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_busy,
  output logic               div_done,
  output logic               mem_timeout
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] dcnt;
  logic             div_accept;
  logic             mem_wait;

  // A new divide is refused while one is running, during the flush
  // cycle, and in the cycle an exception commits.
  assign div_accept = div_start && (dcnt == '0) && !flush && !exc_valid;
  assign div_busy   = !flush && (div_accept || (dcnt > ONE));
  assign div_done   = !flush && (dcnt == ONE);

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || flush || exc_valid) begin
      dcnt <= '0;
    end else if (div_accept) begin
      dcnt <= DIV_LOAD;
    end else if (dcnt != '0) begin
      dcnt <= dcnt - 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      flush  <= 1'b0;
      new_pc <= PC_INIT;
    end else if (exc_valid && !flush) begin
      flush  <= 1'b1;
      new_pc <= exc_pc;
    end else begin
      flush  <= 1'b0;
    end
  end

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mem_wait_timer (
    .clk        (cpu_clk_50M),
    .rst        (cpu_rst),
    .flush      (flush),
    .clear      (exc_valid),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .wait_stall (mem_wait),
    .timeout    (mem_timeout)
  );

  // Highest-priority active request alone selects the vector.
  always_comb begin
    stall = STALL_NONE;
    if (flush) begin
      stall = STALL_NONE;
    end else if (mem_wait) begin
      stall = STALL_MEM;
    end else if (div_busy) begin
      stall = STALL_EXE;
    end else if (stallreq_id && !cpu_rst) begin
      stall = STALL_ID;
    end
  end

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl with DIV_CYCLES = 4 and
// MEM_TIMEOUT = 8 so divide and timeout boundaries are reached quickly.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int DIVC = 4;
  localparam int MTO  = 8;
  localparam logic [31:0] EPC  = 32'hBFC0_0380;
  localparam logic [31:0] EPC2 = 32'h8000_0180;

  typedef struct {
    string       tag;
    bit          chk;
    logic [5:0]  stall;
    logic        flush;
    bit          chk_pc;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, id, ds, mreq, mack, exc;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush, busy, done, tmo;
  logic [31:0] new_pc;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  pipe_stall_ctrl #(.DIV_CYCLES(DIVC), .MEM_TIMEOUT(MTO), .CNT_W(8)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .stallreq_id (id),
    .div_start   (ds),
    .mem_req     (mreq),
    .mem_ack     (mack),
    .exc_valid   (exc),
    .exc_pc      (epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .div_busy    (busy),
    .div_done    (done),
    .mem_timeout (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    if (!e.chk) return;
    vectors++;
    assert (stall === e.stall) else begin
      miscompares++;
      $error("[TB] FAIL %s.stall observed=%b expected=%b", e.tag, stall, e.stall);
    end
    vectors++;
    assert (flush === e.flush) else begin
      miscompares++;
      $error("[TB] FAIL %s.flush observed=%b expected=%b", e.tag, flush, e.flush);
    end
    vectors++;
    assert (busy === e.busy) else begin
      miscompares++;
      $error("[TB] FAIL %s.div_busy observed=%b expected=%b", e.tag, busy, e.busy);
    end
    vectors++;
    assert (done === e.done) else begin
      miscompares++;
      $error("[TB] FAIL %s.div_done observed=%b expected=%b", e.tag, done, e.done);
    end
    vectors++;
    assert (tmo === e.tmo) else begin
      miscompares++;
      $error("[TB] FAIL %s.mem_timeout observed=%b expected=%b", e.tag, tmo, e.tmo);
    end
    if (e.chk_pc) begin
      vectors++;
      assert (new_pc === e.pc) else begin
        miscompares++;
        $error("[TB] FAIL %s.new_pc observed=%h expected=%h", e.tag, new_pc, e.pc);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic applyStimulus(
    input string       tag,
    input bit          chk,
    input logic        i_rst, i_id, i_ds, i_mreq, i_mack, i_exc,
    input logic [31:0] i_epc,
    input logic [5:0]  e_stall,
    input logic        e_flush,
    input bit          e_chk_pc,
    input logic [31:0] e_pc,
    input logic        e_busy, e_done, e_tmo
  );
    exp_t e;
    rst = i_rst; id = i_id; ds = i_ds; mreq = i_mreq; mack = i_mack;
    exc = i_exc; epc = i_epc;
    e.tag = tag; e.chk = chk; e.stall = e_stall; e.flush = e_flush;
    e.chk_pc = e_chk_pc; e.pc = e_pc; e.busy = e_busy; e.done = e_done;
    e.tmo = e_tmo;
    sb.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id = 1'b0; ds = 1'b0; mreq = 1'b0; mack = 1'b0;
    exc = 1'b0; epc = '0;

    // Reset values (first posedge at t=5 has already applied reset)
    applyStimulus("rst0", 1, 1,0,0,0,0,0, '0, STALL_NONE, 0, 1, PC_INIT, 0,0,0);
    applyStimulus("rst1", 1, 1,0,0,0,0,0, '0, STALL_NONE, 0, 1, PC_INIT, 0,0,0);
    applyStimulus("idle", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 1, PC_INIT, 0,0,0);

    // ID hazard for one cycle
    applyStimulus("id_on",  1, 0,1,0,0,0,0, '0, STALL_ID,   0, 0, '0, 0,0,0);
    applyStimulus("id_off", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // Divide: busy t..t+2, done t+3; second start at t+1 ignored
    applyStimulus("div_t0", 1, 0,0,1,0,0,0, '0, STALL_EXE,  0, 0, '0, 1,0,0);
    applyStimulus("div_t1", 1, 0,0,1,0,0,0, '0, STALL_EXE,  0, 0, '0, 1,0,0);
    applyStimulus("div_t2", 1, 0,0,0,0,0,0, '0, STALL_EXE,  0, 0, '0, 1,0,0);
    applyStimulus("div_t3", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,1,0);
    applyStimulus("div_t4", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // MEM wait over ID hazard, then ack falls back to ID
    for (int i = 0; i < 3; i++)
      applyStimulus("memid_wait", 1, 0,1,0,1,0,0, '0, STALL_MEM, 0, 0, '0, 0,0,0);
    applyStimulus("memid_ack", 1, 0,1,0,1,1,0, '0, STALL_ID,   0, 0, '0, 0,0,0);
    applyStimulus("memid_end", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // Timeout: 8 wait cycles, forced release, then wait restarts
    for (int i = 0; i < MTO; i++)
      applyStimulus("to_wait", 1, 0,0,0,1,0,0, '0, STALL_MEM, 0, 0, '0, 0,0,0);
    applyStimulus("to_fire",    1, 0,0,0,1,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,1);
    applyStimulus("to_restart", 1, 0,0,0,1,0,0, '0, STALL_MEM,  0, 0, '0, 0,0,0);
    applyStimulus("to_drop",    1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // Timeout with ID request falls back to the ID encoding
    for (int i = 0; i < MTO; i++)
      applyStimulus("toid_wait", 1, 0,1,0,1,0,0, '0, STALL_MEM, 0, 0, '0, 0,0,0);
    applyStimulus("toid_fire", 1, 0,1,0,1,0,0, '0, STALL_ID,   0, 0, '0, 0,0,1);
    applyStimulus("toid_end",  1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // Divide keeps counting under a MEM wait; ack and done coincide
    applyStimulus("dm_t0", 1, 0,0,1,0,0,0, '0, STALL_EXE,  0, 0, '0, 1,0,0);
    applyStimulus("dm_t1", 1, 0,0,0,1,0,0, '0, STALL_MEM,  0, 0, '0, 1,0,0);
    applyStimulus("dm_t2", 1, 0,0,0,1,0,0, '0, STALL_MEM,  0, 0, '0, 1,0,0);
    applyStimulus("dm_t3", 1, 0,0,0,1,1,0, '0, STALL_NONE, 0, 0, '0, 0,1,0);
    applyStimulus("dm_t4", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    // Exception during a busy divide, exc_valid held for two cycles
    applyStimulus("ex_div",   1, 0,0,1,0,0,0, '0,  STALL_EXE,  0, 0, '0,  1,0,0);
    applyStimulus("ex_t",     1, 0,0,0,0,0,1, EPC, STALL_EXE,  0, 0, '0,  1,0,0);
    applyStimulus("ex_flush", 1, 0,1,1,1,0,1, EPC2, STALL_NONE, 1, 1, EPC, 0,0,0);
    applyStimulus("ex_after", 1, 0,0,0,0,0,0, '0,  STALL_NONE, 0, 0, '0,  0,0,0);
    applyStimulus("ex_quiet", 1, 0,0,0,0,0,0, '0,  STALL_NONE, 0, 0, '0,  0,0,0);

    // Divide start in the exception cycle is refused
    applyStimulus("exds_t",  1, 0,0,1,0,0,1, EPC2, STALL_NONE, 0, 0, '0,   0,0,0);
    applyStimulus("exds_fl", 1, 0,0,0,0,0,0, '0,   STALL_NONE, 1, 1, EPC2, 0,0,0);
    applyStimulus("exds_nx", 1, 0,0,0,0,0,0, '0,   STALL_NONE, 0, 0, '0,   0,0,0);

    // Reset in the middle of a divide aborts it with no done pulse
    applyStimulus("rd_div",  1, 0,0,1,0,0,0, '0, STALL_EXE,  0, 0, '0, 1,0,0);
    applyStimulus("rd_rst0", 0, 1,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);
    applyStimulus("rd_rst1", 1, 1,0,0,0,0,0, '0, STALL_NONE, 0, 1, PC_INIT, 0,0,0);
    for (int i = 0; i < DIVC; i++)
      applyStimulus("rd_quiet", 1, 0,0,0,0,0,0, '0, STALL_NONE, 0, 0, '0, 0,0,0);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
